// File: rtl/psum_axis_serializer.sv
// -----------------------------------------------------------------------------
// psum_axis_serializer
//
// Captures one finished partial-sum vector from the compute array into a
// single buffer and streams it out as an AXI4-Stream master, one data word per
// beat, low word first, with TLAST on the final beat. Only one vector is held
// at a time; a vector offered while the buffer is busy is dropped and flagged.
//
// Ports:
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   psum_in         partial-sum vector, sampled only on capture
//   psum_valid      psum_in holds a finished vector
//   psum_ready      serializer can capture a vector (low while in reset)
//   num_beats       beats to emit for the captured vector (0 or > max = full)
//   err_clr         clears overflow_err (a simultaneous new overflow wins)
//   M_AXIS_*        AXI4-Stream master (TDATA/TSTRB/TVALID/TLAST/TREADY)
//   busy            vector captured and not yet fully sent
//   done            one-cycle pulse after the last beat handshake
//   overflow_err    sticky: vector offered while not ready
// -----------------------------------------------------------------------------
module psum_axis_serializer #(
    parameter int PSUM_WIDTH           = 1280,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int MAX_BEATS            = PSUM_WIDTH / C_M_AXIS_TDATA_WIDTH,
    parameter int BEAT_CNT_WIDTH       = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PSUM_WIDTH-1:0]               psum_in,
    input  logic                                psum_valid,
    output logic                                psum_ready,
    input  logic [BEAT_CNT_WIDTH-1:0]           num_beats,
    input  logic                                err_clr,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow_err
);

    localparam int DW = C_M_AXIS_TDATA_WIDTH;
    localparam int SW = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [BEAT_CNT_WIDTH-1:0] MAX_BEATS_W = BEAT_CNT_WIDTH'(MAX_BEATS);
    localparam logic [BEAT_CNT_WIDTH-1:0] ONE         = BEAT_CNT_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_reg, state_next;
    logic [BEAT_CNT_WIDTH-1:0] cnt_reg;
    logic [BEAT_CNT_WIDTH-1:0] beats_lat_reg;
    logic                      done_reg;
    logic                      overflow_reg;

    // Buffer kept as an array of words; beat k is always at word 0 once k
    // beats have been shifted out.
    logic [DW-1:0] buf_reg  [MAX_BEATS];
    logic [DW-1:0] buf_next [MAX_BEATS];

    logic                      capture;
    logic                      beat_fire;
    logic                      last_beat;
    logic                      m_valid;
    logic [BEAT_CNT_WIDTH-1:0] beats_sel;

    // Out-of-range beat requests mean "send the whole vector".
    assign beats_sel = ((num_beats == '0) || (num_beats > MAX_BEATS_W)) ? MAX_BEATS_W : num_beats;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        psum_ready = 1'b0;
        busy       = 1'b0;
        m_valid    = 1'b0;
        capture    = 1'b0;
        beat_fire  = 1'b0;
        last_beat  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by rst so the compute side never sees ready in reset.
                psum_ready = !rst;
                capture    = psum_valid && !rst;
                if (capture) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                busy      = 1'b1;
                m_valid   = 1'b1;
                last_beat = (cnt_reg == beats_lat_reg - ONE);
                beat_fire = M_AXIS_TREADY;
                if (beat_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TLAST  = last_beat;
    assign M_AXIS_TDATA  = m_valid ? buf_reg[0] : '0;
    assign M_AXIS_TSTRB  = {SW{m_valid}};
    assign done          = done_reg;
    assign overflow_err  = overflow_reg;

    // ------------------------------------------------------------------
    // Per-word buffer update: load on capture, shift down one word per beat
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < MAX_BEATS; gi++) begin : g_word
            logic [DW-1:0] shift_in;
            if (gi == MAX_BEATS - 1) begin : g_top
                assign shift_in = '0;
            end else begin : g_mid
                assign shift_in = buf_reg[gi+1];
            end
            assign buf_next[gi] = capture   ? psum_in[gi*DW +: DW] :
                                  beat_fire ? shift_in             :
                                              buf_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, counters, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            beats_lat_reg <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            for (int i = 0; i < MAX_BEATS; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            if (capture) begin
                cnt_reg       <= '0;
                beats_lat_reg <= beats_sel;
            end else if (beat_fire) begin
                cnt_reg <= cnt_reg + ONE;
            end
            done_reg <= beat_fire && last_beat;
            // A new offending offer takes priority over a clear request.
            if (psum_valid && !psum_ready) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

endmodule

// File: doc/psum_axis_serializer.md
Name: psum_axis_serializer

Overview:
- Downstream of the accelerator top: consumes the wide partial-sum vector (psum_out, 1280 bits) when a compute pass finishes.
- Streams that vector to the DMA as an AXI4-Stream master, 32 bits per beat, with TLAST on the final beat.
- Single capture buffer; provides a ready/valid pair toward the compute side, a done pulse and a sticky overflow flag for the control registers (axi_control_3).

Parameters:
PSUM_WIDTH, 1280, width of the partial-sum vector from the compute array
C_M_AXIS_TDATA_WIDTH, 32, AXI-Stream data width
MAX_BEATS, PSUM_WIDTH/C_M_AXIS_TDATA_WIDTH (40), beats in a full vector
BEAT_CNT_WIDTH, 6, width of beat counter and num_beats (must hold MAX_BEATS)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
psum_in  in  PSUM_WIDTH  partial-sum vector; sampled only on capture
psum_valid  in  1  psum_in holds a finished vector
psum_ready  out  1  serializer can capture a vector
num_beats  in  BEAT_CNT_WIDTH  beats to emit for the captured vector; latched on capture
err_clr  in  1  clears overflow_err
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes, all ones whenever TVALID=1
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TLAST  out  1  final beat of the vector
M_AXIS_TREADY  in  1  downstream accepts beat
busy  out  1  vector captured and not yet fully sent
done  out  1  one-cycle pulse after the last beat handshake
overflow_err  out  1  sticky: vector offered while not ready

Behaviour:
- Reset values: psum_ready=0 during reset, 1 in the first cycle after rst deasserts. M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TSTRB=0, busy=0, done=0, overflow_err=0. Beat counter=0, buffer=0.
- States: IDLE, SEND.
  - IDLE: psum_ready=1.
  - Capture occurs on psum_valid && psum_ready. It loads buf<=psum_in, latches beats_lat<=num_beats, sets counter<=0 and moves to SEND.
- num_beats rules: 0 or >MAX_BEATS latches as MAX_BEATS.
- SEND outputs:
  - psum_ready=0, busy=1, TVALID=1.
  - TDATA = buf[31:0] (low word first); beat k carries psum_in[32k+31:32k].
  - TLAST = (counter == beats_lat-1).
- Latency: capture at edge N; first TVALID visible after edge N (registered), i.e. one cycle after the capture cycle.
- Handshake:
  - A beat transfers on TVALID && TREADY. On transfer, buf shifts right by 32 and counter increments.
  - While TVALID && !TREADY, TDATA, TLAST and TSTRB are held stable.
  - TVALID never drops without a handshake, except on rst.
- Last beat: a handshake with TLAST=1 returns the block to IDLE. On the next edge TVALID=0, TLAST=0, busy=0, psum_ready=1, and done=1 for exactly one cycle.
- Throughput: with TREADY held high, n beats take n consecutive cycles. No back-to-back overlap: the next capture happens at the earliest one cycle after the last beat.
- Overflow:
  - psum_valid=1 while psum_ready=0 sets overflow_err on the next edge; that vector is dropped and does not disturb the current stream.
  - overflow_err clears only on rst or err_clr.
  - err_clr and a new overflow in the same cycle: set wins.
- psum_valid held high in IDLE captures exactly once. While SEND, a still-high psum_valid counts as overflow. The compute side must pulse psum_valid for one cycle per vector.
- rst mid-stream: on that edge all outputs return to reset values, the partial vector is discarded and no TLAST is emitted.
- TREADY changes while TVALID=0 have no effect.

Test Plan:
- Full vector: psum_in word k = k+1, num_beats=0, TREADY=1 -> 40 consecutive beats TDATA=1..40; TLAST only on beat 40 (TDATA=40); done pulses once; psum_ready=1 the cycle after.
- Partial: num_beats=5, word k = 32'hA0+k -> beats A0..A4, TLAST on A4, then idle; num_beats=63 -> 40 beats (clamp).
- Backpressure: TREADY pattern 1,0,0,1,0,1… across 8 beats -> TDATA/TLAST stable during stalls; beat order unchanged; beat count exact.
- Overflow: second psum_valid pulse mid-stream -> overflow_err=1 and the current stream is intact. err_clr -> 0. err_clr together with a new offending psum_valid -> stays 1.
- Reset mid-stream: rst after beat 3 of 40 -> next cycle TVALID=0, busy=0, no TLAST. A new vector afterwards streams from word 0.
- Held psum_valid: psum_valid high for 3 cycles in IDLE -> one capture, overflow_err=1 (cycles 2–3 offered while busy).
